// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory responder: funct3 width codes,
// FSM state encoding and common widths.
package riscv_mem_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatting for RV32I loads and stores: load extraction/extension,
// store byte-enables and read-modify-write merge. DMEM_MISALIGN_ERR_EN adds misalignment detection.
module dmem_lane_fmt
    import riscv_mem_pkg::*;
(
    input  logic [2:0]      i_funct3,
    input  logic            i_we,
    input  logic [1:0]      i_addr_lo,
    input  logic [XLEN-1:0] i_ram_word,
    input  logic [XLEN-1:0] i_wdata,
    output logic [XLEN-1:0] o_load_data,
    output logic            o_wr_en,
    output logic [XLEN-1:0] o_wr_word
`ifdef DMEM_MISALIGN_ERR_EN
    ,
    output logic            o_misaligned
`endif
);

    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_st_data;

    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_ram_word[7:0];
            2'd1:    w_byte = i_ram_word[15:8];
            2'd2:    w_byte = i_ram_word[23:16];
            default: w_byte = i_ram_word[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_ram_word[31:16] : i_ram_word[15:0];
    end

`ifdef DMEM_MISALIGN_ERR_EN
    logic w_misaligned;
    always_comb begin
        w_misaligned = 1'b0;
        if ((i_funct3 == F3_H || (!i_we && i_funct3 == F3_HU)) && i_addr_lo[0])
            w_misaligned = 1'b1;
        if (i_funct3 == F3_W && i_addr_lo != 2'd0)
            w_misaligned = 1'b1;
    end
    assign o_misaligned = w_misaligned;
`endif

    // Stores yield no load data; unsupported codes leave both paths inert.
    always_comb begin
        o_load_data = '0;
        w_be        = 4'b0000;
        w_st_data   = i_wdata;
        if (!i_we) begin
            case (i_funct3)
                F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
                F3_BU:   o_load_data = {24'h0, w_byte};
                F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
                F3_HU:   o_load_data = {16'h0, w_half};
                F3_W:    o_load_data = i_ram_word;
                default: o_load_data = '0;
            endcase
        end else begin
            case (i_funct3)
                F3_B: begin
                    w_be      = 4'b0001 << i_addr_lo;
                    w_st_data = {4{i_wdata[7:0]}};
                end
                F3_H: begin
                    w_be      = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                    w_st_data = {2{i_wdata[15:0]}};
                end
                F3_W:    w_be = 4'b1111;
                default: w_be = 4'b0000;
            endcase
        end
`ifdef DMEM_MISALIGN_ERR_EN
        if (w_misaligned) begin
            o_load_data = '0;
            w_be        = 4'b0000;
        end
`endif
    end

    always_comb begin
        for (int i = 0; i < 4; i++)
            o_wr_word[8*i +: 8] = w_be[i] ? w_st_data[8*i +: 8] : i_ram_word[8*i +: 8];
    end

    assign o_wr_en = |w_be;

endmodule

// File: rtl/riscv_dmem_responder.sv
// Data-memory responder: valid/ready request/response FSM, wait-state counter and word RAM.
// DMEM_MISALIGN_ERR_EN adds the rsp_err output and suppresses misaligned accesses.
module riscv_dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [2:0]      req_funct3,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata
`ifdef DMEM_MISALIGN_ERR_EN
    ,
    output logic            rsp_err
`endif
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // a response transfers on a rising edge where rsp_valid && rsp_ready.
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int AW    = IDX_W + 2;
    localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    dmem_state_t     r_state, w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_rdata;
    logic [XLEN-1:0] r_mem [DEPTH_WORDS];

    logic            w_accept;
    logic            w_enter_resp;
    logic            w_acc_we;
    logic [AW-1:0]   w_acc_addr;
    logic [XLEN-1:0] w_acc_wdata;
    logic [2:0]      w_acc_funct3;
    logic [XLEN-1:0] w_ram_word;
    logic [XLEN-1:0] w_load_data;
    logic            w_wr_en;
    logic [XLEN-1:0] w_wr_word;
    logic            w_unused;

    assign w_unused  = &{1'b0, req_addr[XLEN-1:AW]};
    assign req_ready = (r_state == IDLE) && !rst;
    assign w_accept  = req_valid && req_ready;
    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rdata;

    always_comb begin
        w_next_state = r_state;
        w_enter_resp = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (WAIT_CYCLES == 0) begin
                        w_next_state = RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == '0 && !rst) begin
                    w_next_state = RESP;
                    w_enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready)
                    w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // With zero wait states the access happens on the accept edge itself.
    assign w_acc_we     = (r_state == IDLE) ? req_we : r_we;
    assign w_acc_addr   = (r_state == IDLE) ? req_addr[AW-1:0] : r_addr;
    assign w_acc_wdata  = (r_state == IDLE) ? req_wdata : r_wdata;
    assign w_acc_funct3 = (r_state == IDLE) ? req_funct3 : r_funct3;
    assign w_ram_word   = r_mem[w_acc_addr[AW-1:2]];

`ifdef DMEM_MISALIGN_ERR_EN
    logic w_misaligned;
    logic r_err;
    assign rsp_err = r_err;
`endif

    dmem_lane_fmt u_lane_fmt (
        .i_funct3    (w_acc_funct3),
        .i_we        (w_acc_we),
        .i_addr_lo   (w_acc_addr[1:0]),
        .i_ram_word  (w_ram_word),
        .i_wdata     (w_acc_wdata),
        .o_load_data (w_load_data),
        .o_wr_en     (w_wr_en),
        .o_wr_word   (w_wr_word)
`ifdef DMEM_MISALIGN_ERR_EN
        ,
        .o_misaligned(w_misaligned)
`endif
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_funct3 <= '0;
            r_rdata  <= '0;
`ifdef DMEM_MISALIGN_ERR_EN
            r_err    <= 1'b0;
`endif
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_we     <= req_we;
                r_addr   <= req_addr[AW-1:0];
                r_wdata  <= req_wdata;
                r_funct3 <= req_funct3;
                r_cnt    <= CNT_INIT;
            end else if (r_state == WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_enter_resp) begin
                r_rdata <= w_load_data;
`ifdef DMEM_MISALIGN_ERR_EN
                r_err   <= w_misaligned;
`endif
            end
        end
    end

    // RAM contents survive reset; writes only on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (!rst && w_enter_resp && w_wr_en)
            r_mem[w_acc_addr[AW-1:2]] <= w_wr_word;
    end

endmodule
